// File: rtl/gb_host_bridge.sv
// Host-side ghostbus master: byte-stream command packets in, single-cycle gb_we/gb_re strobes out, read data back as bytes.
// Optional burst support (word count from CMD[3:0], address auto-increment) is enabled by defining GHOSTBUS_BRIDGE_AUTOINC_EN.
module gb_host_bridge #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we,
    output logic          gb_re,
    output logic          busy
);

    localparam int AB = AW / 8;
    localparam int DB = DW / 8;

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_WDATA, S_WSTB, S_RSTB, S_RWAIT, S_RESP
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          dir_r;
    logic [7:0]    byte_cnt_r;
    logic [2:0]    lat_cnt_r;
    logic [DW-1:0] rdata_r;
    logic [DW-1:0] rdata_shift_s;
    logic          rx_fire_s;
    logic          tx_fire_s;
    logic          addr_last_s;
    logic          data_last_s;
    logic          lat_done_s;
    logic          last_word_s;

    assign rx_fire_s     = rx_valid & rx_ready;
    assign tx_fire_s     = tx_valid & tx_ready;
    assign addr_last_s   = (byte_cnt_r == 8'(AB - 1));
    assign data_last_s   = (byte_cnt_r == 8'(DB - 1));
    assign lat_done_s    = (lat_cnt_r == 3'(RD_LATENCY));
    assign rdata_shift_s = rdata_r << 8;

`ifdef GHOSTBUS_BRIDGE_AUTOINC_EN
    logic [3:0] words_left_r;
    assign last_word_s = (words_left_r == 4'd0);
`else
    assign last_word_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_CMD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_CMD: begin
                if (rx_fire_s) state_next_s = S_ADDR;
                else           state_next_s = S_CMD;
            end
            S_ADDR: begin
                if (rx_fire_s && addr_last_s) state_next_s = dir_r ? S_WDATA : S_RSTB;
                else                          state_next_s = S_ADDR;
            end
            S_WDATA: begin
                if (rx_fire_s && data_last_s) state_next_s = S_WSTB;
                else                          state_next_s = S_WDATA;
            end
            S_WSTB:  state_next_s = last_word_s ? S_CMD : S_WDATA;
            S_RSTB:  state_next_s = S_RWAIT;
            S_RWAIT: begin
                if (lat_done_s) state_next_s = S_RESP;
                else            state_next_s = S_RWAIT;
            end
            S_RESP: begin
                if (tx_fire_s && data_last_s) state_next_s = last_word_s ? S_CMD : S_RSTB;
                else                          state_next_s = S_RESP;
            end
            default: state_next_s = S_CMD;
        endcase
    end

    // Registered outputs follow the next state so strobes last exactly one state-cycle and drop on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready   <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'd0;
            gb_addr    <= {AW{1'b0}};
            gb_dout    <= {DW{1'b0}};
            gb_we      <= 1'b0;
            gb_re      <= 1'b0;
            busy       <= 1'b0;
            dir_r      <= 1'b0;
            byte_cnt_r <= 8'd0;
            lat_cnt_r  <= 3'd0;
            rdata_r    <= {DW{1'b0}};
`ifdef GHOSTBUS_BRIDGE_AUTOINC_EN
            words_left_r <= 4'd0;
`endif
        end else begin
            rx_ready <= (state_next_s == S_CMD) || (state_next_s == S_ADDR) || (state_next_s == S_WDATA);
            tx_valid <= (state_next_s == S_RESP);
            gb_we    <= (state_next_s == S_WSTB);
            gb_re    <= (state_next_s == S_RSTB);
            busy     <= (state_next_s != S_CMD);
            case (state_r)
                S_CMD: begin
                    if (rx_fire_s) begin
                        dir_r      <= rx_data[7];
                        byte_cnt_r <= 8'd0;
`ifdef GHOSTBUS_BRIDGE_AUTOINC_EN
                        words_left_r <= rx_data[3:0];
`endif
                    end
                end
                S_ADDR: begin
                    if (rx_fire_s) begin
                        gb_addr    <= (gb_addr << 8) | AW'(rx_data);
                        byte_cnt_r <= addr_last_s ? 8'd0 : byte_cnt_r + 8'd1;
                    end
                end
                S_WDATA: begin
                    if (rx_fire_s) begin
                        gb_dout    <= (gb_dout << 8) | DW'(rx_data);
                        byte_cnt_r <= data_last_s ? 8'd0 : byte_cnt_r + 8'd1;
                    end
                end
                S_WSTB: begin
`ifdef GHOSTBUS_BRIDGE_AUTOINC_EN
                    if (!last_word_s) begin
                        gb_addr      <= gb_addr + AW'(1);
                        words_left_r <= words_left_r - 4'd1;
                    end
`endif
                end
                S_RSTB: lat_cnt_r <= 3'd1;
                S_RWAIT: begin
                    if (lat_done_s) begin
                        rdata_r    <= gb_din;
                        tx_data    <= gb_din[DW-1 -: 8];
                        byte_cnt_r <= 8'd0;
                    end else begin
                        lat_cnt_r  <= lat_cnt_r + 3'd1;
                    end
                end
                S_RESP: begin
                    if (tx_fire_s) begin
                        if (data_last_s) begin
                            byte_cnt_r <= 8'd0;
`ifdef GHOSTBUS_BRIDGE_AUTOINC_EN
                            if (!last_word_s) begin
                                gb_addr      <= gb_addr + AW'(1);
                                words_left_r <= words_left_r - 4'd1;
                            end
`endif
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 8'd1;
                            rdata_r    <= rdata_shift_s;
                            tx_data    <= rdata_shift_s[DW-1 -: 8];
                        end
                    end
                end
                default: byte_cnt_r <= 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_host_bridge.sv
// Scoreboard bench for gb_host_bridge: expected bus strobes and tx bytes are queued at stimulus time and popped by a monitor.
module tb_gb_host_bridge;

    localparam int RD_LAT = 2;
`ifdef GHOSTBUS_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] gb_addr;
    logic [31:0] gb_dout;
    logic [31:0] gb_din;
    logic        gb_we;
    logic        gb_re;
    logic        busy;

    gb_host_bridge #(.AW(24), .DW(32), .RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_din(gb_din),
        .gb_we(gb_we), .gb_re(gb_re), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [23:0] exp_re_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [31:0] ref_ram[logic [23:0]];
    logic [31:0] bus_mem[logic [23:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    int n_re    = 0;
    int bp      = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [23:0] a);
        if (a == 24'h000004) return 32'h12345678;
        return {8'hA5, a} ^ 32'h00C3_3C5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [23:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_val(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [23:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
    endfunction

    // Ghostbus slave: stores writes, returns read data exactly RD_LAT cycles after the strobe cycle
    logic        rd_v [0:7];
    logic [23:0] rd_a [0:7];
    initial begin
        for (int i = 0; i < 8; i++) begin
            rd_v[i] = 1'b0;
            rd_a[i] = 24'd0;
        end
        forever begin
            @(posedge clk);
            if (gb_we) bus_mem[gb_addr] = gb_dout;
            for (int i = 7; i > 0; i--) begin
                rd_v[i] = rd_v[i-1];
                rd_a[i] = rd_a[i-1];
            end
            rd_v[0] = gb_re;
            rd_a[0] = gb_addr;
            gb_din <= rd_v[RD_LAT-1] ? bus_rd(rd_a[RD_LAT-1]) : 32'hDEAD0BAD;
        end
    end

    // Monitor and tx back-pressure driver
    logic       prev_we = 1'b0;
    logic       prev_re = 1'b0;
    logic       tx_stalled = 1'b0;
    logic [7:0] prev_tx = 8'd0;
    int         stall_cnt = 0;
    initial begin
        wr_t e;
        logic [23:0] ea;
        logic [7:0]  eb;
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gb_we || gb_re)
                    chk_eq("strobe_rules", {61'd0, gb_we & gb_re, gb_we & prev_we, gb_re & prev_re}, 64'd0);
                if (gb_we) begin
                    n_we++;
                    if (exp_wr_q.size() == 0) begin
                        chk_eq("unexpected_we", 64'd1, 64'd0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk_eq("we_addr", 64'(gb_addr), 64'(e.addr));
                        chk_eq("we_data", 64'(gb_dout), 64'(e.data));
                    end
                end
                if (gb_re) begin
                    n_re++;
                    if (exp_re_q.size() == 0) begin
                        chk_eq("unexpected_re", 64'd1, 64'd0);
                    end else begin
                        ea = exp_re_q.pop_front();
                        chk_eq("re_addr", 64'(gb_addr), 64'(ea));
                    end
                end
                if (tx_stalled) begin
                    chk_eq("tx_hold_data", 64'(tx_data), 64'(prev_tx));
                    chk_eq("tx_hold_valid", 64'(tx_valid), 64'd1);
                end
            end
            prev_we = gb_we;
            prev_re = gb_re;
            if (tx_valid) begin
                if (stall_cnt < bp) begin
                    tx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    tx_ready = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
                stall_cnt = 0;
            end
            if (!rst && tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    chk_eq("unexpected_tx", 64'(tx_data), 64'hFFFF);
                end else begin
                    eb = exp_tx_q.pop_front();
                    chk_eq("tx_byte", 64'(tx_data), 64'(eb));
                end
            end
            tx_stalled = !rst && tx_valid && !tx_ready;
            prev_tx = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        rx_valid = 1'b0;
        repeat (g) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk_eq("rx_timeout", 64'd1, 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic wr, input logic [3:0] cnt, input logic [23:0] addr,
                            input logic rnd, input logic [31:0] dbase, input int gap);
        int words;
        logic [23:0] a;
        logic [31:0] d;
        wr_t e;
        words = AUTOINC ? int'(cnt) + 1 : 1;
        if (!wr) begin
            for (int w = 0; w < words; w++) begin
                a = addr + 24'(w);
                exp_re_q.push_back(a);
                d = ref_rd(a);
                for (int b = 0; b < 4; b++) exp_tx_q.push_back(d[31-8*b -: 8]);
            end
        end
        send_byte({wr, 3'b000, cnt}, gap);
        for (int i = 0; i < 3; i++) send_byte(addr[23-8*i -: 8], gap);
        if (wr) begin
            for (int w = 0; w < words; w++) begin
                a = addr + 24'(w);
                d = rnd ? 32'($urandom) : dbase + 32'(w);
                ref_ram[a] = d;
                e.addr = a;
                e.data = d;
                exp_wr_q.push_back(e);
                for (int b = 0; b < 4; b++) send_byte(d[31-8*b -: 8], gap);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || exp_re_q.size() != 0 || exp_tx_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_reached", 64'(n < 5000), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk_eq({tag, "_outs"}, {56'd0, rx_ready, tx_valid, gb_we, gb_re, busy, 3'd0}, 64'd0);
        chk_eq({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk_eq({tag, "_gb_addr"}, 64'(gb_addr), 64'd0);
        chk_eq({tag, "_gb_dout"}, 64'(gb_dout), 64'd0);
    endtask

    initial begin
        int we0;
        int re0;
        logic [23:0] a;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rx_ready_after_reset", 64'(rx_ready), 64'd1);
        chk_eq("busy_idle", 64'(busy), 64'd0);

        // single write
        send_pkt(1'b1, 4'd0, 24'h000100, 1'b0, 32'hDEADBEEF, 0);
        wait_idle();
        chk_eq("busy_after_write", 64'(busy), 64'd0);
        chk_eq("write_count", 64'(n_we), 64'd1);

        // single read, then same read with 5-cycle stall per byte
        send_pkt(1'b0, 4'd0, 24'h000004, 1'b0, 32'd0, 0);
        wait_idle();
        re0 = n_re;
        bp = 5;
        send_pkt(1'b0, 4'd0, 24'h000004, 1'b0, 32'd0, 0);
        wait_idle();
        chk_eq("bp_read_count", 64'(n_re - re0), 64'd1);
        bp = 0;

        // reset mid write packet
        we0 = n_we;
        send_byte(8'h80, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("midpkt");
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rx_ready_after_midpkt", 64'(rx_ready), 64'd1);
        send_pkt(1'b0, 4'd0, 24'h000004, 1'b0, 32'd0, 0);
        wait_idle();
        chk_eq("no_we_after_abort", 64'(n_we - we0), 64'd0);

        // wrapping burst read
        re0 = n_re;
        send_pkt(1'b0, 4'd2, 24'hFFFFFF, 1'b0, 32'd0, 0);
        wait_idle();
        chk_eq("burst_read_count", 64'(n_re - re0), AUTOINC ? 64'd3 : 64'd1);

        // random mixed traffic
        for (int p = 0; p < 100; p++) begin
            a = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 12)) : 24'hFFFFF0 + 24'($urandom_range(0, 15));
            bp = int'($urandom_range(0, 2));
            send_pkt(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), a, 1'b1, 32'd0, 3);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
